// File: rtl/frame_sync_pkg.sv
// Shared constants for the frame sync controller: register map, STATUS/CTRL bit positions,
// and a saturating counter helper.
package frame_sync_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_FRAME  = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int unsigned StatusW      = 16;
  localparam int unsigned ST_PENDING   = 0;
  localparam int unsigned ST_VBLANK    = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_MISSED    = 8;
  localparam int unsigned MissedW      = 8;

  localparam int unsigned CTRL_IRQ_EN   = 0;
  localparam int unsigned CTRL_AUTO_CLR = 1;

  function automatic logic [MissedW-1:0] sat_inc(input logic [MissedW-1:0] val);
    return (val == '1) ? val : val + MissedW'(1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop level synchronizer with synchronous active-low reset.
module sync2 (
  input  logic clk,
  input  logic resetq,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!resetq) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame counter with divided frame tick, pending/overrun status, missed-tick counter,
// CPU register interface and level interrupt.
module frame_sync_ctrl
  import frame_sync_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             vsync,
  input  logic             vblank,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [1:0]       io_addr,
  input  logic [CNT_W-1:0] io_din,
  output logic [CNT_W-1:0] io_dout,
  output logic             irq
);

  logic               vblank_s;

  logic [CNT_W-1:0]   frame_q,   frame_d;
  logic [DIV_W-1:0]   div_q,     div_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               irq_en_q,  irq_en_d;
  logic               auto_clr_q, auto_clr_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic [MissedW-1:0] missed_q,  missed_d;
  logic [CNT_W-1:0]   io_dout_q, io_dout_d;
  logic               irq_q,     irq_d;

  logic               tick;
  logic               ovr_evt;
  logic               wr_status, wr_frame, wr_div, wr_ctrl;
  logic               pend_clr, ovr_clr;
  logic [StatusW-1:0] status_w;
  logic [1:0]         ctrl_w;
  logic [CNT_W-1:0]   rdata;

  sync2 u_sync_vblank (
    .clk    (clk),
    .resetq (resetq),
    .d      (vblank),
    .q      (vblank_s)
  );

  always_comb begin
    wr_status = io_wr && (io_addr == ADDR_STATUS);
    wr_frame  = io_wr && (io_addr == ADDR_FRAME);
    wr_div    = io_wr && (io_addr == ADDR_DIV);
    wr_ctrl   = io_wr && (io_addr == ADDR_CTRL);

    tick    = vsync && (div_cnt_q == div_q);
    ovr_evt = tick && pending_q;

    // A read paired with a write has no side effects, so auto-clear needs a lone read.
    pend_clr = (wr_status && io_din[ST_PENDING]) ||
               (io_rd && !io_wr && (io_addr == ADDR_STATUS) && auto_clr_q);
    ovr_clr  = wr_status && io_din[ST_OVERRUN];
  end

  // Set beats clear throughout the status logic.
  always_comb begin
    pending_d = pending_q;
    if (tick) begin
      pending_d = 1'b1;
    end else if (pend_clr) begin
      pending_d = 1'b0;
    end

    overrun_d = overrun_q;
    missed_d  = missed_q;
    if (ovr_evt) begin
      overrun_d = 1'b1;
      missed_d  = sat_inc(missed_q);
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
      missed_d  = '0;
    end
  end

  always_comb begin
    frame_d = frame_q;
    if (wr_frame) begin
      frame_d = io_din;
    end else if (vsync) begin
      frame_d = frame_q + CNT_W'(1);
    end

    div_d     = wr_div ? io_din[DIV_W-1:0] : div_q;
    div_cnt_d = div_cnt_q;
    if (wr_div) begin
      div_cnt_d = '0;
    end else if (vsync) begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    end

    irq_en_d   = wr_ctrl ? io_din[CTRL_IRQ_EN]   : irq_en_q;
    auto_clr_d = wr_ctrl ? io_din[CTRL_AUTO_CLR] : auto_clr_q;

    irq_d = pending_q && irq_en_q;
  end

  // Read data is built from current (pre-update) state.
  always_comb begin
    status_w                         = '0;
    status_w[ST_PENDING]             = pending_q;
    status_w[ST_VBLANK]              = vblank_s;
    status_w[ST_OVERRUN]             = overrun_q;
    status_w[ST_MISSED +: MissedW]   = missed_q;

    ctrl_w                = '0;
    ctrl_w[CTRL_IRQ_EN]   = irq_en_q;
    ctrl_w[CTRL_AUTO_CLR] = auto_clr_q;

    rdata = '0;
    unique case (io_addr)
      ADDR_STATUS: rdata = CNT_W'(status_w);
      ADDR_FRAME:  rdata = frame_q;
      ADDR_DIV:    rdata = CNT_W'(div_q);
      ADDR_CTRL:   rdata = CNT_W'(ctrl_w);
      default:     rdata = '0;
    endcase

    io_dout_d = io_rd ? rdata : io_dout_q;
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      frame_q    <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      irq_en_q   <= 1'b0;
      auto_clr_q <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      missed_q   <= '0;
      io_dout_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      frame_q    <= frame_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      irq_en_q   <= irq_en_d;
      auto_clr_q <= auto_clr_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      missed_q   <= missed_d;
      io_dout_q  <= io_dout_d;
      irq_q      <= irq_d;
    end
  end

  assign io_dout = io_dout_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed bench for frame_sync_ctrl: hand-computed register and irq expectations.
module tb_frame_sync_ctrl;

  logic        clk;
  logic        resetq;
  logic        vsync;
  logic        vblank;
  logic        io_rd;
  logic        io_wr;
  logic [1:0]  io_addr;
  logic [15:0] io_din;
  logic [15:0] io_dout;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  frame_sync_ctrl #(
    .CNT_W (16),
    .DIV_W (8)
  ) dut (
    .clk     (clk),
    .resetq  (resetq),
    .vsync   (vsync),
    .vblank  (vblank),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .io_din  (io_din),
    .io_dout (io_dout),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    io_wr = 1'b1; io_addr = a; io_din = d;
    step();
    io_wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    io_rd = 1'b1; io_addr = a;
    step();
    io_rd = 1'b0;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1;
      step();
    end
    vsync = 1'b0;
  endtask

  task automatic do_reset();
    resetq = 1'b0;
    step();
    resetq = 1'b1;
  endtask

  initial begin
    resetq = 1'b0; vsync = 1'b0; vblank = 1'b0;
    io_rd = 1'b0; io_wr = 1'b0; io_addr = 2'd0; io_din = 16'h0;
    step(); step(); step();
    check("reset_dout", io_dout, 16'h0000);
    check("reset_irq", {15'b0, irq}, 16'h0000);
    resetq = 1'b1;
    rd(2'd0); check("reset_status", io_dout, 16'h0000);
    rd(2'd1); check("reset_frame", io_dout, 16'h0000);

    // DIV=0: every vsync ticks
    pulse(3);
    check("div0_irq", {15'b0, irq}, 16'h0000);
    rd(2'd0); check("div0_status", io_dout, 16'h0205);
    rd(2'd1); check("div0_frame", io_dout, 16'h0003);
    step(); step();
    check("dout_hold", io_dout, 16'h0003);

    // DIV=2 with irq enabled
    do_reset();
    wr(2'd2, 16'h0002);
    wr(2'd3, 16'h0001);
    pulse(2);
    check("div2_irq_p2", {15'b0, irq}, 16'h0000);
    pulse(1);
    check("div2_irq_p3", {15'b0, irq}, 16'h0000);
    step();
    check("div2_irq_rise", {15'b0, irq}, 16'h0001);
    rd(2'd0); check("div2_status", io_dout, 16'h0001);
    wr(2'd0, 16'h0001);
    check("irq_hold_after_clr", {15'b0, irq}, 16'h0001);
    step();
    check("irq_fall", {15'b0, irq}, 16'h0000);

    // Ticking vsync coincident with write-1-clear of pending
    pulse(3);
    pulse(2);
    vsync = 1'b1; io_wr = 1'b1; io_addr = 2'd0; io_din = 16'h0001;
    step();
    vsync = 1'b0; io_wr = 1'b0;
    rd(2'd0); check("set_wins", io_dout, 16'h0105);
    wr(2'd0, 16'h0004);
    rd(2'd0); check("ovr_clr", io_dout, 16'h0001);
    wr(2'd0, 16'h0001);
    rd(2'd0); check("pend_clr", io_dout, 16'h0000);

    // FRAME wrap and write-vs-vsync
    wr(2'd1, 16'hFFFF);
    pulse(1);
    rd(2'd1); check("frame_wrap", io_dout, 16'h0000);
    io_rd = 1'b1; io_wr = 1'b1; io_addr = 2'd1; io_din = 16'h00AA;
    step();
    io_rd = 1'b0; io_wr = 1'b0;
    check("rdwr_old", io_dout, 16'h0000);
    rd(2'd1); check("rdwr_new", io_dout, 16'h00AA);
    vsync = 1'b1; io_wr = 1'b1; io_addr = 2'd1; io_din = 16'h1234;
    step();
    vsync = 1'b0; io_wr = 1'b0;
    rd(2'd1); check("frame_wr_wins", io_dout, 16'h1234);

    // Auto-clear and vblank synchronizer
    wr(2'd3, 16'h0002);
    rd(2'd3); check("ctrl_read", io_dout, 16'h0002);
    pulse(1);
    rd(2'd0); check("autoclr_first", io_dout, 16'h0001);
    rd(2'd0); check("autoclr_after", io_dout, 16'h0000);
    vblank = 1'b1;
    step(); step();
    rd(2'd0); check("vblank_rise", io_dout, 16'h0002);
    vblank = 1'b0;
    step();
    rd(2'd0); check("vblank_lag", io_dout, 16'h0002);
    rd(2'd0); check("vblank_fall", io_dout, 16'h0000);

    // Missed saturation
    wr(2'd2, 16'h0000);
    wr(2'd3, 16'h0000);
    pulse(200);
    rd(2'd0); check("missed_199", io_dout, 16'hC705);
    pulse(101);
    rd(2'd0); check("missed_sat", io_dout, 16'hFF05);
    rd(2'd1); check("frame_count", io_dout, 16'h1362);
    wr(2'd3, 16'h0001);
    step();
    check("irq_pre_reset", {15'b0, irq}, 16'h0001);

    // Reset mid-run with strobes active
    resetq = 1'b0; vsync = 1'b1; io_wr = 1'b1; io_rd = 1'b1; io_addr = 2'd1; io_din = 16'h5555;
    step();
    resetq = 1'b1; vsync = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
    check("midrst_dout", io_dout, 16'h0000);
    check("midrst_irq", {15'b0, irq}, 16'h0000);
    rd(2'd0); check("midrst_status", io_dout, 16'h0000);
    rd(2'd1); check("midrst_frame", io_dout, 16'h0000);
    rd(2'd2); check("midrst_div", io_dout, 16'h0000);
    rd(2'd3); check("midrst_ctrl", io_dout, 16'h0000);
    pulse(1);
    rd(2'd0); check("resume_status", io_dout, 16'h0001);
    rd(2'd1); check("resume_frame", io_dout, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_sync_ctrl.md
FRAME_SYNC_CTRL -- requirements
Module: frame_sync_ctrl

Parameters
REQ-001 SHALL have parameter CNT_W, default 16, width of frame counter and I/O data.
REQ-002 SHALL have parameter DIV_W, default 8, width of frame divider.

Interface
REQ-003 SHALL have clk  input  1  system (CPU) clock; all logic on posedge.
REQ-004 SHALL have resetq  input  1  synchronous active-low reset.
REQ-005 SHALL have vsync  input  1  one-clk frame-start pulse, already in clk domain.
REQ-006 SHALL have vblank  input  1  asynchronous level from pixel-clock timing generator.
REQ-007 SHALL have io_rd  input  1  CPU read strobe, one cycle.
REQ-008 SHALL have io_wr  input  1  CPU write strobe, one cycle.
REQ-009 SHALL have io_addr  input  2  register select: 0 STATUS, 1 FRAME, 2 DIV, 3 CTRL.
REQ-010 SHALL have io_din  input  CNT_W  write data.
REQ-011 SHALL have io_dout  output  CNT_W  registered read data.
REQ-012 SHALL have irq  output  1  registered interrupt request, level.

Function
REQ-013 SHALL pass vblank through a two-flop synchronizer; vblank_s is the second flop.
REQ-014 SHALL increment FRAME by 1 on each vsync, wrapping 2^CNT_W-1 -> 0.
REQ-015 SHALL keep div_cnt (DIV_W); on vsync: if div_cnt == DIV then div_cnt <= 0 and a tick occurs, else div_cnt += 1.
REQ-016 SHALL, on tick with pending = 0, set pending.
REQ-017 SHALL, on tick with pending = 1, set overrun and increment missed (8-bit, saturating at 255).
REQ-018 SHALL read STATUS as {missed[7:0], 5'b0, overrun, vblank_s, pending}.
REQ-019 SHALL clear pending/overrun on STATUS write where io_din bit0/bit2 = 1; bit2 write-1 also clears missed.
REQ-020 SHALL, on simultaneous tick and write-1-clear of pending, leave pending = 1 (set wins); same for overrun/missed.
REQ-021 SHALL, when CTRL.bit1 (auto-clear) = 1, clear pending on an io_rd of STATUS; set wins on same-cycle tick.
REQ-022 SHALL load FRAME from io_din on write to addr 1; same-cycle vsync is ignored for FRAME (write wins).
REQ-023 SHALL load DIV from io_din[DIV_W-1:0] on write to addr 2 and force div_cnt <= 0 in same cycle.
REQ-024 SHALL hold CTRL bit0 irq_en, bit1 auto_clr; other bits read 0.
REQ-025 SHALL drive irq <= pending & irq_en, one cycle after either changes.
REQ-026 SHALL present io_dout one cycle after io_rd; io_dout holds last value otherwise.
REQ-027 SHALL return the pre-update value for a read coinciding with vsync or write.
REQ-028 SHALL ignore io_rd and io_wr asserted together except that the write takes effect and read data is returned.

Reset
REQ-029 SHALL, on clk edge with resetq = 0: FRAME, div_cnt, DIV, CTRL, pending, overrun, missed, io_dout, irq, synchronizer flops all 0.
REQ-030 SHALL, with resetq = 0 mid-frame, ignore vsync and io strobes in that cycle; counting resumes from 0 on the first vsync after release.

Structure
REQ-031 SHALL place register address constants (ADDR_STATUS..ADDR_CTRL) and STATUS bit positions in shared package frame_sync_pkg.
REQ-032 SHALL implement the two-flop synchronizer as sub-module sync2 (reusable for other pixclk-domain levels).
REQ-033 SHALL target 120-400 lines of RTL, no inferred memories.

Verification
REQ-034 SHALL cover: reset, DIV=0, 3 vsync pulses, no reads -> FRAME=3, pending=1, overrun=1, missed=2, irq=0 (irq_en=0).
REQ-035 SHALL cover: DIV=2, irq_en=1, 3 vsync -> pending and irq rise exactly after 3rd pulse (+1 clk for irq); STATUS write 0x0001 -> irq falls next cycle.
REQ-036 SHALL cover: pending=1, write 0x0001 to STATUS on same clk as ticking vsync -> pending stays 1, overrun=1, missed increments.
REQ-037 SHALL cover: FRAME=0xFFFF, vsync -> FRAME=0x0000; write FRAME=0x1234 with coincident vsync -> FRAME=0x1234.
REQ-038 SHALL cover: auto_clr=1, read STATUS -> io_dout bit0=1 next cycle, pending=0 after; vblank toggled -> STATUS bit1 follows after 2 clk.
REQ-039 SHALL cover: 300 overrun ticks -> missed saturates at 255; resetq low mid-run -> all registers 0 next edge.
